rsi_feed_scheduler: RTL and testbench

Arbitration and sequencing controller that shares one RSI signal engine between four per-stock price feeds. Each feed offers 14-bit price samples over a valid/ready handshake. A round-robin arbiter picks one eligible feed and presents the tagged sample `{stock_id, price}` to the engine with a one-cycle enable. The engine's buy/sell decision is captured and returned on a backpressured result port. The block sits between the market-data ingress and the engine and guarantees exactly one engine update per accepted sample.

---
 rtl/rsi_sched_pkg.sv | 20 ++
 rtl/rsi_rr_arbiter.sv | 39 +++
 rtl/rsi_feed_scheduler.sv | 111 +++++++++++
 tb/tb_rsi_feed_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rsi_sched_pkg.sv
// Shared constants, FSM state type and sample-word packing for the RSI feed scheduler.
package rsi_sched_pkg;
    localparam int NUM_STOCKS = 4;
    localparam int PRICE_W    = 14;
    localparam int ID_W       = 2;
    localparam int WORD_W     = ID_W + PRICE_W;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } sched_state_t;

    function automatic logic [WORD_W-1:0] pack_sample(input logic [ID_W-1:0]    id,
                                                      input logic [PRICE_W-1:0] price);
        return {id, price};
    endfunction
endpackage

// File: rtl/rsi_rr_arbiter.sv
// Four-way combinational round-robin pick; scanning starts at rr_ptr and wraps.
module rsi_rr_arbiter
    import rsi_sched_pkg::*;
(
    input  logic [NUM_STOCKS-1:0] eligible,
    input  logic [ID_W-1:0]       rr_ptr,
    output logic [NUM_STOCKS-1:0] grant_onehot,
    output logic [ID_W-1:0]       grant_idx,
    output logic                  any
);
    logic [NUM_STOCKS-1:0] rotated;
    logic [ID_W-1:0]       cand_idx [NUM_STOCKS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STOCKS; gi++) begin : g_rot
            // 2-bit add gives the modulo-4 wrap for free
            assign cand_idx[gi] = rr_ptr + ID_W'(gi);
            assign rotated[gi]  = eligible[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        for (int i = NUM_STOCKS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                grant_idx = cand_idx[i];
                any       = 1'b1;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_STOCKS; gi++) begin : g_onehot
            assign grant_onehot[gi] = any && (grant_idx == ID_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/rsi_feed_scheduler.sv
// Shares one RSI engine between four price feeds: arbitrate, issue one engine
// update per accepted sample, capture the decision and hand it out on a backpressured port.
module rsi_feed_scheduler
    import rsi_sched_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_STOCKS-1:0]         req_valid,
    input  logic [NUM_STOCKS*PRICE_W-1:0] req_price,
    output logic [NUM_STOCKS-1:0]         req_ready,
    input  logic [NUM_STOCKS-1:0]         stock_mask,
    output logic                          eng_enable,
    output logic [WORD_W-1:0]             eng_price_in,
    input  logic                          eng_buy,
    input  logic                          eng_sell,
    input  logic [ID_W-1:0]               eng_stock_id,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ID_W-1:0]               res_stock_id,
    output logic                          res_buy,
    output logic                          res_sell,
    output logic                          busy,
    output logic [CNT_W-1:0]              issue_count,
    output logic                          id_mismatch
);
    sched_state_t          state_reg, state_next;
    logic [ID_W-1:0]       rr_ptr_reg;
    logic [WORD_W-1:0]     word_reg;
    logic [ID_W-1:0]       res_stock_id_reg;
    logic                  res_buy_reg, res_sell_reg;
    logic [CNT_W-1:0]      issue_count_reg;
    logic                  id_mismatch_reg;

    logic [NUM_STOCKS-1:0] eligible, grant_onehot;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_any, accept;
    logic [PRICE_W-1:0]    price_arr [NUM_STOCKS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STOCKS; gi++) begin : g_price
            assign price_arr[gi] = req_price[gi*PRICE_W +: PRICE_W];
        end
    endgenerate

    assign eligible = req_valid & stock_mask;

    rsi_rr_arbiter u_arb (
        .eligible     (eligible),
        .rr_ptr       (rr_ptr_reg),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    // Only IDLE grants, so res_ready never reaches req_ready combinationally
    assign accept    = (state_reg == IDLE) && grant_any;
    assign req_ready = (state_reg == IDLE) ? grant_onehot : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            rr_ptr_reg       <= '0;
            word_reg         <= '0;
            res_stock_id_reg <= '0;
            res_buy_reg      <= 1'b0;
            res_sell_reg     <= 1'b0;
            issue_count_reg  <= '0;
            id_mismatch_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rr_ptr_reg <= grant_idx + ID_W'(1);
                word_reg   <= pack_sample(grant_idx, price_arr[grant_idx]);
            end
            if (state_reg == ISSUE && issue_count_reg != {CNT_W{1'b1}}) begin
                issue_count_reg <= issue_count_reg + CNT_W'(1);
            end
            if (state_reg == CAPTURE) begin
                res_stock_id_reg <= eng_stock_id;
                res_buy_reg      <= eng_buy;
                res_sell_reg     <= eng_sell;
                if (eng_stock_id != word_reg[WORD_W-1 -: ID_W]) begin
                    id_mismatch_reg <= 1'b1;
                end
            end
        end
    end

    // The latched word doubles as the engine input and simply holds between updates
    assign eng_price_in = word_reg;
    assign eng_enable   = (state_reg == ISSUE);
    assign res_valid    = (state_reg == RESP);
    assign res_stock_id = res_stock_id_reg;
    assign res_buy      = res_buy_reg;
    assign res_sell     = res_sell_reg;
    assign busy         = (state_reg != IDLE);
    assign issue_count  = issue_count_reg;
    assign id_mismatch  = id_mismatch_reg;
endmodule

// File: tb/tb_rsi_feed_scheduler.sv
// Scoreboard bench for rsi_feed_scheduler: a queue-based reference model predicts grants,
// engine words and results; separate monitors compare whatever the DUT presents.
module tb_rsi_feed_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [55:0] req_price;
    logic [3:0]  req_ready;
    logic [3:0]  stock_mask;
    logic        eng_enable;
    logic [15:0] eng_price_in;
    logic        eng_buy, eng_sell;
    logic [1:0]  eng_stock_id;
    logic        res_valid, res_ready;
    logic [1:0]  res_stock_id;
    logic        res_buy, res_sell, busy;
    logic [15:0] issue_count;
    logic        id_mismatch;

    always #5 clk = ~clk;

    rsi_feed_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_price(req_price),
        .req_ready(req_ready), .stock_mask(stock_mask), .eng_enable(eng_enable),
        .eng_price_in(eng_price_in), .eng_buy(eng_buy), .eng_sell(eng_sell),
        .eng_stock_id(eng_stock_id), .res_valid(res_valid), .res_ready(res_ready),
        .res_stock_id(res_stock_id), .res_buy(res_buy), .res_sell(res_sell),
        .busy(busy), .issue_count(issue_count), .id_mismatch(id_mismatch)
    );

    // Engine model: simple threshold decision, echoed id optionally corrupted
    logic corrupt_cur = 1'b0;
    assign eng_buy      = (eng_price_in[13:0] < 14'h1000);
    assign eng_sell     = (eng_price_in[13:0] >= 14'h3000);
    assign eng_stock_id = eng_price_in[15:14] ^ {corrupt_cur, 1'b0};

    typedef struct { int cyc; logic [15:0] word; } eng_item_t;
    typedef struct { int cyc; logic [1:0] id; logic buy; logic sell; logic mm; logic [15:0] cnt; } res_item_t;
    eng_item_t eq[$];
    res_item_t rq[$];

    int checks = 0, failures = 0, cyc = 0;
    bit mon_en = 1'b0;

    // stimulus / model state
    logic [3:0]  pend = '0, feed_en = '0, mask_cfg = 4'hF;
    logic [13:0] fprice [4];
    bit mask_rand = 0, stall_arm = 0, corrupt_on3 = 0, model_busy = 0, model_mm = 0;
    int refill_pct = 0, rr_pct = 100, stall_left = 0;
    int model_ptr = 0, resp_cyc = 0, model_cnt = 0, last_win = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic [3:0] elig, exp_ready;
        int win;
        @(negedge clk);
        elig = req_valid & stock_mask;
        exp_ready = '0;
        win = -1;
        if (!model_busy) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (model_ptr + k) % 4;
                if (win < 0 && elig[idx]) win = idx;
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(model_busy));
        last_win = win;
        if (win >= 0) begin
            logic [13:0] p;
            p = fprice[win];
            corrupt_cur = corrupt_on3 && (win == 3);
            if (corrupt_cur) corrupt_on3 = 0;
            model_cnt = (model_cnt == 65535) ? 65535 : model_cnt + 1;
            model_mm  = model_mm | corrupt_cur;
            eq.push_back('{cyc: cyc + 1, word: {2'(win), p}});
            rq.push_back('{cyc: cyc + 3, id: 2'(win) ^ {corrupt_cur, 1'b0},
                           buy: (p < 14'h1000), sell: (p >= 14'h3000),
                           mm: model_mm, cnt: 16'(model_cnt)});
            $display("ACCEPT cyc=%0d stock=%0d price=0x%0h", cyc, win, p);
            pend[win]  = 1'b0;
            model_ptr  = (win + 1) % 4;
            model_busy = 1;
            resp_cyc   = cyc + 3;
        end else if (model_busy && cyc >= resp_cyc && res_ready) begin
            model_busy = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (stall_arm && model_busy && cyc == resp_cyc) begin
            stall_left = 5;
            stall_arm  = 0;
        end
        if (stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
        end else begin
            res_ready = ($urandom_range(0, 99) < rr_pct);
        end
        for (int i = 0; i < 4; i++) begin
            if (!pend[i] && feed_en[i] && $urandom_range(0, 99) < refill_pct) begin
                pend[i]   = 1'b1;
                fprice[i] = 14'($urandom_range(0, 16383));
            end
        end
        stock_mask = mask_rand ? 4'($urandom) : mask_cfg;
        req_valid  = pend;
        for (int i = 0; i < 4; i++) req_price[i*14 +: 14] = fprice[i];
    endtask

    task automatic drain();
        int n = 0;
        feed_en = '0; mask_rand = 0; mask_cfg = 4'hF; rr_pct = 100;
        while ((pend != '0 || model_busy) && n < 200) begin
            step();
            n++;
        end
        chk("drain_done", 32'(n < 200), 32'd1);
    endtask

    // Engine-side monitor
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (eq.size() > 0 && eq[0].cyc == cyc) begin
                    chk("eng_enable", 32'(eng_enable), 32'd1);
                    chk("eng_price_in", 32'(eng_price_in), 32'(eq[0].word));
                    void'(eq.pop_front());
                end else begin
                    chk("eng_enable_idle", 32'(eng_enable), 32'd0);
                end
            end
        end
    end

    // Result-side monitor; compares every RESP cycle so stalls prove stability
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rq.size() > 0 && cyc >= rq[0].cyc) begin
                    chk("res_valid", 32'(res_valid), 32'd1);
                    chk("res_stock_id", 32'(res_stock_id), 32'(rq[0].id));
                    chk("res_buy", 32'(res_buy), 32'(rq[0].buy));
                    chk("res_sell", 32'(res_sell), 32'(rq[0].sell));
                    chk("id_mismatch", 32'(id_mismatch), 32'(rq[0].mm));
                    chk("issue_count", 32'(issue_count), 32'(rq[0].cnt));
                    if (res_ready) begin
                        $display("RESULT cyc=%0d stock=%0d buy=%0d sell=%0d", cyc,
                                 rq[0].id, rq[0].buy, rq[0].sell);
                        void'(rq.pop_front());
                    end
                end else begin
                    chk("res_valid_idle", 32'(res_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_price = '0; stock_mask = 4'hF; res_ready = 1'b1;
        for (int i = 0; i < 4; i++) fprice[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_eng_enable", 32'(eng_enable), 32'd0);
        chk("rst_eng_price_in", 32'(eng_price_in), 32'd0);
        chk("rst_res", 32'({res_valid, res_stock_id, res_buy, res_sell}), 32'd0);
        chk("rst_issue_count", 32'(issue_count), 32'd0);
        chk("rst_id_mismatch", 32'(id_mismatch), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // single feed: stock 2, price 0x0123
        pend[2] = 1'b1; fprice[2] = 14'h0123;
        repeat (8) step();
        // all four valid continuously
        feed_en = 4'hF; refill_pct = 100;
        repeat (24) step();
        // only stocks 1 and 3 eligible
        mask_cfg = 4'b1010;
        repeat (24) step();
        // five-cycle result stall
        mask_cfg = 4'hF; stall_arm = 1;
        repeat (16) step();
        // wrong echoed id on a stock 3 grant, then clean samples
        corrupt_on3 = 1;
        repeat (24) step();
        // randomized traffic
        refill_pct = 30; mask_rand = 1; rr_pct = 60;
        repeat (1500) step();
        drain();

        // reset arriving in the ISSUE cycle
        pend[1] = 1'b1; fprice[1] = 14'h0456;
        begin
            int n = 0;
            last_win = -1;
            while (last_win != 1 && n < 10) begin
                step();
                n++;
            end
            chk("rst_test_accept", 32'(last_win), 32'd1);
        end
        rst = 1'b1;
        mon_en = 1'b0;
        eq.delete();
        rq.delete();
        @(negedge clk);
        chk("issue_before_rst", 32'(eng_enable), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_eng_enable", 32'(eng_enable), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_res_valid", 32'(res_valid), 32'd0);
        chk("post_rst_issue_count", 32'(issue_count), 32'd0);
        model_ptr = 0; model_busy = 0; model_cnt = 0; model_mm = 0; corrupt_cur = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        repeat (4) step();
        feed_en = 4'hF; refill_pct = 100;
        repeat (14) step();
        drain();
        chk("eq_empty", 32'(eq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
